// File: rtl/core_fetch_ctrl.sv
// core_fetch_ctrl: instruction-fetch bus sequencer for the prefetch buffer.
// Issues word-aligned reads under an outstanding-credit limit, returns data
// in order, and on redirect flushes the prefetch and drains stale responses.
// Build option: define FETCH_PERF_EN to build the three perf counters;
// when it is left undefined the perf ports are tied to zero.
module core_fetch_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter logic [29:0] RESET_PC        = 30'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch,
    input  logic        redirect,
    input  logic [30:0] redirect_target,
    output logic        insn_start,
    output logic [29:0] insn_addr,
    input  logic        insn_ready,
    input  logic        insn_rvalid,
    input  logic [31:0] insn_rdata,
    output logic        fetched,
    output logic [31:0] fetch_data,
    output logic        pf_flush,
    output logic [30:0] pf_head,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded,
    output logic [31:0] perf_stall
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [29:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic               req_pending_q, req_pending_d;

    logic               rvalid_live;
    logic               can_issue;
    logic               accept;
    logic [CNT_W-1:0]   stale_cnt;

    // A response only counts against the credit when one is actually owed.
    assign rvalid_live = insn_rvalid && (outstanding_q != '0);
    assign can_issue   = (state_q == RUN) && fetch &&
                         (outstanding_q < CNT_W'(MAX_OUTSTANDING));
    assign insn_start  = !redirect && (req_pending_q || can_issue);
    assign accept      = insn_start && insn_ready;
    assign stale_cnt   = outstanding_q - CNT_W'(rvalid_live);

    // Bus-facing and prefetch-facing outputs.
    assign insn_addr   = fetch_pc_q;
    assign fetched     = rvalid_live && (state_q == RUN) && !redirect;
    assign fetch_data  = insn_rdata;
    assign pf_flush    = redirect;
    assign pf_head     = redirect_target;

    // State, PC, credit counter and held-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            req_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            req_pending_q <= req_pending_d;
        end
    end

    // Next-state: redirect retargets and withdraws; otherwise advance on accept.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pending_d = req_pending_q;
        outstanding_d = outstanding_q + CNT_W'(accept) - CNT_W'(rvalid_live);

        if (redirect) begin
            fetch_pc_d    = redirect_target[30:1];
            req_pending_d = 1'b0;
            state_d       = (stale_cnt != '0) ? DRAIN : RUN;
        end else begin
            if (accept) begin
                fetch_pc_d    = fetch_pc_q + 30'd1;
                req_pending_d = 1'b0;
            end else if (insn_start) begin
                req_pending_d = 1'b1;
            end

            if ((state_q == DRAIN) && (outstanding_d == '0)) begin
                state_d = RUN;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_discarded_q;
    logic [31:0] perf_stall_q;
    logic        discard;
    logic        stall;

    assign discard = insn_rvalid && !fetched;
    assign stall   = insn_start && !insn_ready;

    // Free-running wrapping event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q   <= 32'd0;
            perf_discarded_q <= 32'd0;
            perf_stall_q     <= 32'd0;
        end else begin
            perf_fetched_q   <= perf_fetched_q + 32'(fetched);
            perf_discarded_q <= perf_discarded_q + 32'(discard);
            perf_stall_q     <= perf_stall_q + 32'(stall);
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_discarded = perf_discarded_q;
    assign perf_stall     = perf_stall_q;
`else
    assign perf_fetched   = 32'd0;
    assign perf_discarded = 32'd0;
    assign perf_stall     = 32'd0;
`endif

endmodule
